// File: rtl/ballot_controller.sv
// One-ballot-per-arm vote capture front end: edge-detects candidate buttons,
// read-modify-writes the selected candidate's count, then enforces a lockout.
module ballot_controller #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 4,
  parameter int LOCK_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ballot_enable,
  input  logic [NUM_CAND-1:0]       cand_btn,
  input  logic                      close_poll,
  input  logic [NUM_CAND*CNT_W-1:0] count_in,
  output logic [NUM_CAND*CNT_W-1:0] wr_data,
  output logic [NUM_CAND-1:0]       wr_en,
  output logic                      ready,
  output logic                      vote_done,
  output logic                      invalid,
  output logic                      overflow,
  output logic                      closed
);

  localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int POP_W = $clog2(NUM_CAND + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARMED, COMMIT, LOCK, CLOSED} state_t;

  state_t                    state, next_state;
  logic [NUM_CAND-1:0]       btn_q;
  logic [NUM_CAND-1:0]       press;
  logic [POP_W-1:0]          press_cnt;
  logic [IDX_W-1:0]          press_idx;
  logic [CNT_W-1:0]          sel_cnt;
  logic                      close_pend;
  logic [LCK_W-1:0]          lock_cnt;
  logic                      lock_exit;
  logic [NUM_CAND*CNT_W-1:0] nx_wr_data;
  logic [NUM_CAND-1:0]       nx_wr_en;
  logic                      nx_vote_done, nx_invalid, nx_overflow;

  assign press = cand_btn & ~btn_q;

  always_comb begin
    press_cnt = '0;
    press_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (press[i]) begin
        press_cnt = press_cnt + POP_W'(1);
        press_idx = IDX_W'(i);
      end
    end
  end

  assign sel_cnt   = count_in[int'(press_idx)*CNT_W +: CNT_W];
  assign lock_exit = (lock_cnt == '0) && (cand_btn == '0);

  always_comb begin
    next_state   = state;
    nx_wr_en     = '0;
    nx_wr_data   = count_in;
    nx_vote_done = 1'b0;
    nx_invalid   = 1'b0;
    nx_overflow  = 1'b0;
    case (state)
      IDLE: begin
        if (close_poll)         next_state = CLOSED;
        else if (ballot_enable) next_state = ARMED;
      end
      ARMED: begin
        if (close_poll) begin
          next_state = CLOSED;
        end else if (press_cnt == POP_W'(1)) begin
          next_state   = COMMIT;
          nx_vote_done = 1'b1;
          // A full counter saturates: flag it and leave memory untouched.
          if (sel_cnt != CNT_MAX) begin
            nx_wr_en[press_idx] = 1'b1;
            nx_wr_data[int'(press_idx)*CNT_W +: CNT_W] = sel_cnt + CNT_W'(1);
          end else begin
            nx_overflow = 1'b1;
          end
        end else if (press_cnt >= POP_W'(2)) begin
          nx_invalid = 1'b1;
        end
      end
      COMMIT: next_state = LOCK;
      LOCK: begin
        if (lock_exit) next_state = (close_pend || close_poll) ? CLOSED : IDLE;
      end
      CLOSED:  next_state = CLOSED;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      btn_q <= '0;
    end else begin
      state <= next_state;
      btn_q <= cand_btn;
    end
  end

  // Counter is loaded as the vote is accepted, so LOCK lasts LOCK_CYCLES cycles
  // when buttons are already released.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt   <= '0;
      close_pend <= 1'b0;
    end else begin
      if (state == ARMED && next_state == COMMIT)
        lock_cnt <= LCK_W'(LOCK_CYCLES);
      else if ((state == COMMIT || state == LOCK) && lock_cnt != '0)
        lock_cnt <= lock_cnt - LCK_W'(1);
      if ((state == COMMIT || state == LOCK) && close_poll)
        close_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data   <= '0;
      wr_en     <= '0;
      ready     <= 1'b0;
      vote_done <= 1'b0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      closed    <= 1'b0;
    end else begin
      wr_data   <= nx_wr_data;
      wr_en     <= nx_wr_en;
      ready     <= (next_state == ARMED);
      vote_done <= nx_vote_done;
      invalid   <= nx_invalid;
      overflow  <= nx_overflow;
      closed    <= (next_state == CLOSED);
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: voting, invalid presses, saturation,
// lockout timing, poll close and reset during COMMIT.
module tb_ballot_controller;

  logic        clk;
  logic        reset;
  logic        ballot_enable;
  logic [3:0]  cand_btn;
  logic        close_poll;
  logic [15:0] count_in;
  logic [15:0] wr_data;
  logic [3:0]  wr_en;
  logic        ready, vote_done, invalid, overflow, closed;

  int tests_run = 0;
  int tests_failed = 0;

  ballot_controller #(.NUM_CAND(4), .CNT_W(4), .LOCK_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .ballot_enable(ballot_enable), .cand_btn(cand_btn),
    .close_poll(close_poll), .count_in(count_in), .wr_data(wr_data), .wr_en(wr_en),
    .ready(ready), .vote_done(vote_done), .invalid(invalid), .overflow(overflow),
    .closed(closed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the inputs, then advances one edge and lets outputs settle.
  task automatic applyStimulus(input logic arm, input logic [3:0] btn, input logic cls);
    ballot_enable = arm;
    cand_btn      = btn;
    close_poll    = cls;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_wr_en, input logic [15:0] e_wr_data,
                             input logic e_vote, input logic e_inv, input logic e_ovf,
                             input logic e_ready, input logic e_closed);
    checkVal({tag, ".wr_en"},     {12'd0, wr_en},     {12'd0, e_wr_en});
    checkVal({tag, ".wr_data"},   wr_data,            e_wr_data);
    checkVal({tag, ".vote_done"}, {15'd0, vote_done}, {15'd0, e_vote});
    checkVal({tag, ".invalid"},   {15'd0, invalid},   {15'd0, e_inv});
    checkVal({tag, ".overflow"},  {15'd0, overflow},  {15'd0, e_ovf});
    checkVal({tag, ".ready"},     {15'd0, ready},     {15'd0, e_ready});
    checkVal({tag, ".closed"},    {15'd0, closed},    {15'd0, e_closed});
  endtask

  initial begin
    reset = 1'b1; ballot_enable = 1'b0; cand_btn = 4'd0; close_poll = 1'b0; count_in = 16'h0000;
    applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("reset", 4'd0, 16'h0000, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Test 1: vote for cand 2 at count 3, then measure lockout with arm held
    count_in = 16'h0300;
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("t1_armed", 4'd0, 16'h0300, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("t1_vote", 4'b0100, 16'h0400, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0);
      checkOutput($sformatf("t1_lock%0d", i), 4'd0, 16'h0300, 0, 0, 0, 0, 0);
    end
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("t1_rearm", 4'd0, 16'h0300, 0, 0, 0, 1, 0);

    // Test 2: double press is invalid, then a single press writes once
    count_in = 16'h0021;
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("t2_invalid", 4'd0, 16'h0021, 0, 1, 0, 1, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("t2_still_armed", 4'd0, 16'h0021, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("t2_vote", 4'b0010, 16'h0031, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("t2_after", 4'd0, 16'h0021, 0, 0, 0, 0, 0);
    repeat (8) applyStimulus(1'b0, 4'd0, 1'b0);

    // Test 3: saturated candidate raises overflow and writes nothing
    count_in = 16'hF000;
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("t3_armed", 4'd0, 16'hF000, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("t3_overflow", 4'd0, 16'hF000, 1, 0, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("t3_after", 4'd0, 16'hF000, 0, 0, 0, 0, 0);
    repeat (8) applyStimulus(1'b0, 4'd0, 1'b0);

    // Test 4: held button and re-arm during lock: no second vote, IDLE only after release
    count_in = 16'h0005;
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t4_vote", 4'b0001, 16'h0006, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b0001, 1'b0);
      checkOutput($sformatf("t4_held%0d", i), 4'd0, 16'h0005, 0, 0, 0, 0, 0);
    end
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("t4_release", 4'd0, 16'h0005, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("t4_rearm", 4'd0, 16'h0005, 0, 0, 0, 1, 0);

    // Test 5: close_poll during LOCK closes the poll once the lock expires
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("t5_vote", 4'b0010, 16'h0015, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("t5_lock%0d", i), 4'd0, 16'h0005, 0, 0, 0, 0, 0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("t5_closed", 4'd0, 16'h0005, 0, 0, 0, 0, 1);
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t5_ignored", 4'd0, 16'h0005, 0, 0, 0, 0, 1);

    // Test 6: reset during COMMIT drops the vote; held button is not a new press
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("t6_reset", 4'd0, 16'h0000, 0, 0, 0, 0, 0);
    reset = 1'b0;
    count_in = 16'h0007;
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t6_commit", 4'b0001, 16'h0008, 1, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t6_reset_commit", 4'd0, 16'h0000, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b0);
    checkOutput("t6_armed", 4'd0, 16'h0007, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t6_held", 4'd0, 16'h0007, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t6_repress", 4'b0001, 16'h0008, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
